// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multi-cycle multiply/divide/accumulate engine:
// operation codes, FSM state encodings and small decode helpers.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MdMult  = 3'd0,
    MdMultu = 3'd1,
    MdMadd  = 3'd2,
    MdMaddu = 3'd3,
    MdMsub  = 3'd4,
    MdMsubu = 3'd5,
    MdDiv   = 3'd6,
    MdDivu  = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    MdIdle   = 3'd0,
    MdMul    = 3'd1,
    MdAcc    = 3'd2,
    MdDivRun = 3'd3,
    MdDone   = 3'd4
  } md_state_e;

  localparam logic DivByZero         = 1'b1;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  function automatic logic op_is_signed(md_op_e op);
    return op inside {MdMult, MdMadd, MdMsub, MdDiv};
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return op inside {MdDiv, MdDivu};
  endfunction

  function automatic logic op_is_acc(md_op_e op);
    return op inside {MdMadd, MdMaddu, MdMsub, MdMsubu};
  endfunction

  function automatic logic op_is_msub(md_op_e op);
    return op inside {MdMsub, MdMsubu};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module muldiv_unit_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  // i_rem < divisor keeps w_shift < 2*divisor, so the top bit is a clean borrow
  assign o_q     = ~w_diff[WIDTH];
  assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MADD/MSUB/DIV engine producing a {HI,LO} result; operands
// are latched as magnitudes and the sign fixup is applied on the final edge.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DIV_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o,
  output logic               stallreq_o
);

  localparam int unsigned NIter = WIDTH / DIV_STEP;
  localparam int unsigned CntW  = $clog2(NIter) + 1;

  md_state_e          r_state, w_state_next;
  md_op_e             r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_rem;
  logic [2*WIDTH-1:0] r_hilo, r_prod, r_result;
  logic [CntW-1:0]    r_cnt;
  logic               r_neg_q, r_neg_r, r_dbz;

  md_op_e             w_op;
  logic               w_accept, w_a_neg, w_b_neg, w_div_zero, w_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo_next, w_quo_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_prod_abs, w_prod_fix;
  logic [WIDTH-1:0]   w_rem [DIV_STEP+1];
  logic [DIV_STEP-1:0] w_qbits;

  assign w_op       = md_op_e'(op_i);
  assign w_accept   = (r_state == MdIdle) && start_i && !annul_i;
  assign w_a_neg    = op_is_signed(w_op) && opdata1_i[WIDTH-1];
  assign w_b_neg    = op_is_signed(w_op) && opdata2_i[WIDTH-1];
  assign w_abs_a    = w_a_neg ? -opdata1_i : opdata1_i;
  assign w_abs_b    = w_b_neg ? -opdata2_i : opdata2_i;
  assign w_div_zero = (opdata2_i == '0);
  assign w_last     = (r_cnt == CntW'(NIter - 1));

  assign w_prod_abs = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_prod_fix = r_neg_q ? -w_prod_abs : w_prod_abs;

  // r_a doubles as the dividend/quotient shift register during DIV_RUN
  assign w_rem[0] = r_rem;
  for (genvar k = 0; k < DIV_STEP; k++) begin : g_div
    muldiv_unit_div_step #(
      .WIDTH(WIDTH)
    ) u_div_step (
      .i_rem    (w_rem[k]),
      .i_bit    (r_a[WIDTH-1-k]),
      .i_divisor(r_b),
      .o_rem    (w_rem[k+1]),
      .o_q      (w_qbits[DIV_STEP-1-k])
    );
  end
  assign w_quo_next = {r_a[WIDTH-1-DIV_STEP:0], w_qbits};
  assign w_quo_fix  = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_rem_fix  = r_neg_r ? -w_rem[DIV_STEP] : w_rem[DIV_STEP];

  always_ff @(posedge clk) begin
    if (rst) r_state <= MdIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      MdIdle: begin
        if (w_accept) begin
          if (!op_is_div(w_op)) w_state_next = MdMul;
          else                  w_state_next = w_div_zero ? MdDone : MdDivRun;
        end
      end
      MdMul:    w_state_next = op_is_acc(r_op) ? MdAcc : MdDone;
      MdAcc:    w_state_next = MdDone;
      MdDivRun: if (w_last) w_state_next = MdDone;
      MdDone:   w_state_next = MdIdle;
      default:  w_state_next = MdIdle;
    endcase
    if (annul_i) w_state_next = MdIdle;
  end

  always_comb begin
    ready_o       = (r_state == MdDone) ? DivResultReady : DivResultNotReady;
    busy_o        = (r_state != MdIdle);
    div_by_zero_o = ready_o && (r_dbz == DivByZero);
    stallreq_o    = start_i && !ready_o;
    result_o      = r_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= MdMult;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_hilo   <= '0;
      r_prod   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_a     <= w_abs_a;
      r_b     <= w_abs_b;
      r_rem   <= '0;
      r_hilo  <= hilo_i;
      r_cnt   <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dbz   <= op_is_div(w_op) && w_div_zero;
      if (op_is_div(w_op) && w_div_zero) r_result <= '0;
    end else if (!annul_i) begin
      unique case (r_state)
        MdMul: begin
          r_prod <= w_prod_fix;
          if (!op_is_acc(r_op)) r_result <= w_prod_fix;
        end
        MdAcc: r_result <= op_is_msub(r_op) ? r_hilo - r_prod : r_hilo + r_prod;
        MdDivRun: begin
          r_a   <= w_quo_next;
          r_rem <= w_rem[DIV_STEP];
          r_cnt <= r_cnt + CntW'(1);
          if (w_last) r_result <= {w_rem_fix, w_quo_fix};
        end
        default: ;
      endcase
    end
  end

endmodule
